// File: rtl/posit_decode.sv
// posit<32,3> operand unpacker: sign, regime k, exponent, hidden-1 mantissa; 4..34 cycles (operand-dependent serial regime scan).
// No backpressure: start is honoured only while idle, results hold until the next decode overwrites them.
module posit_decode (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [31:0] posit_in,
   output logic        sign_out,
   output logic [5:0]  k_out,
   output logic [2:0]  exp_out,
   output logic [31:0] mantissa_out,
   output logic        is_zero,
   output logic        is_nar,
   output logic        busy,
   output logic        done
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_LOAD     = 3'd1,
      S_SCAN     = 3'd2,
      S_EXTRACT  = 3'd3,
      S_COMPLETE = 3'd4
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] opnd_q, opnd_d;
   logic        sgn_q, sgn_d;
   logic        r0_q, r0_d;
   logic [4:0]  m_q, m_d;
   logic [4:0]  ptr_q, ptr_d;
   logic        sign_q, sign_d;
   logic [5:0]  k_q, k_d;
   logic [2:0]  exp_q, exp_d;
   logic [31:0] mant_q, mant_d;
   logic        zero_q, zero_d;
   logic        nar_q, nar_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;

   logic [31:0] abs_v;
   logic [31:0] rem_v;
   logic [5:0]  sh_v;
   logic [4:0]  ptr_m1;

   always_comb begin
      state_d = state_q;
      opnd_d  = opnd_q;
      sgn_d   = sgn_q;
      r0_d    = r0_q;
      m_d     = m_q;
      ptr_d   = ptr_q;
      sign_d  = sign_q;
      k_d     = k_q;
      exp_d   = exp_q;
      mant_d  = mant_q;
      zero_d  = zero_q;
      nar_d   = nar_q;
      busy_d  = busy_q;
      done_d  = done_q;
      abs_v   = opnd_q[31] ? (~opnd_q + 32'd1) : opnd_q;
      sh_v    = {1'b0, m_q} + 6'd2;
      rem_v   = (sh_v >= 6'd32) ? 32'd0 : (opnd_q << sh_v);
      ptr_m1  = ptr_q - 5'd1;

      case (state_q)
         S_IDLE: begin
            done_d = 1'b0;
            if (start) begin
               opnd_d  = posit_in;
               busy_d  = 1'b1;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            if (opnd_q[30:0] == 31'd0) begin
               // 0 and NaR share all-zero fields and differ only in the flag
               sign_d  = 1'b0;
               k_d     = 6'd0;
               exp_d   = 3'd0;
               mant_d  = 32'd0;
               zero_d  = ~opnd_q[31];
               nar_d   = opnd_q[31];
               state_d = S_COMPLETE;
            end else begin
               sgn_d   = opnd_q[31];
               opnd_d  = abs_v;
               r0_d    = abs_v[30];
               m_d     = 5'd0;
               ptr_d   = 5'd30;
               state_d = S_SCAN;
            end
         end
         S_SCAN: begin
            if (opnd_q[ptr_q] == r0_q) begin
               m_d   = m_q + 5'd1;
               ptr_d = ptr_m1;
            end
            if ((ptr_q == 5'd0) || (opnd_q[ptr_m1] != r0_q)) begin
               state_d = S_EXTRACT;
            end
         end
         S_EXTRACT: begin
            sign_d  = sgn_q;
            k_d     = r0_q ? ({1'b0, m_q} - 6'd1) : (6'd0 - {1'b0, m_q});
            exp_d   = rem_v[31:29];
            mant_d  = {1'b1, rem_v[28:0], 2'b00};
            zero_d  = 1'b0;
            nar_d   = 1'b0;
            state_d = S_COMPLETE;
         end
         S_COMPLETE: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         opnd_q  <= 32'd0;
         sgn_q   <= 1'b0;
         r0_q    <= 1'b0;
         m_q     <= 5'd0;
         ptr_q   <= 5'd0;
         sign_q  <= 1'b0;
         k_q     <= 6'd0;
         exp_q   <= 3'd0;
         mant_q  <= 32'd0;
         zero_q  <= 1'b0;
         nar_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         opnd_q  <= opnd_d;
         sgn_q   <= sgn_d;
         r0_q    <= r0_d;
         m_q     <= m_d;
         ptr_q   <= ptr_d;
         sign_q  <= sign_d;
         k_q     <= k_d;
         exp_q   <= exp_d;
         mant_q  <= mant_d;
         zero_q  <= zero_d;
         nar_q   <= nar_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign sign_out     = sign_q;
   assign k_out        = k_q;
   assign exp_out      = exp_q;
   assign mantissa_out = mant_q;
   assign is_zero      = zero_q;
   assign is_nar       = nar_q;
   assign busy         = busy_q;
   assign done         = done_q;

endmodule
